// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract unit for wide operands.
// Each cycle adds one CHUNK-bit slice, starting with the LSB slice. The carry
// between slices is held in a register, so the longest carry chain is CHUNK bits.
// Subtraction is a + ~b + ~cin. The raw carry out is reported, so for a
// subtraction the borrow-out is ~cout.
module seq_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // The operand registers shift right by one slice per RUN cycle, so the
  // slice being added is always in the low CHUNK bits.
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic [WIDTH-1:0] sum_run;
  logic             carry_reg, carry_next;
  logic             cout_reg, cout_next;
  logic             ovf_reg, ovf_next;
  logic [IDXW-1:0]  idx_reg, idx_next;

  logic [CHUNK-1:0]  slice_a;
  logic [CHUNK-1:0]  slice_b;
  logic [CHUNK-1:0]  slice_s;
  logic              slice_c;
  logic              msb_cin;
  logic [NCHUNK-1:0] slice_we;

  assign slice_a = a_reg[CHUNK-1:0];
  assign slice_b = b_reg[CHUNK-1:0];

  // Add one slice, including the carry held from the previous slice.
  assign {slice_c, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, carry_reg};

  // The carry into the top bit of the slice is recovered from that bit's sum,
  // because sum = a ^ b ^ carry_in. On the last slice this is the carry into the MSB.
  assign msb_cin = slice_s[CHUNK-1] ^ slice_a[CHUNK-1] ^ slice_b[CHUNK-1];

  // Only the slice selected by the index is updated. All other result bits
  // keep their earlier values.
  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
      assign slice_we[gi] = (state_reg == RUN) && (idx_reg == IDXW'(gi));
      assign sum_run[gi*CHUNK +: CHUNK] = slice_we[gi] ? slice_s : sum_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  // Next-state and datapath update; every register holds unless its state assigns it.
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    sum_next   = sum_reg;
    carry_next = carry_reg;
    cout_next  = cout_reg;
    ovf_next   = ovf_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next = RUN;
          a_next     = a;
          b_next     = sub ? ~b : b;
          carry_next = sub ? ~cin : cin;
          idx_next   = '0;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        sum_next   = sum_run;
        carry_next = slice_c;
        a_next     = a_reg >> CHUNK;
        b_next     = b_reg >> CHUNK;
        if (idx_reg == LAST_IDX) begin
          cout_next  = slice_c;
          ovf_next   = msb_cin ^ slice_c;
          state_next = DONE;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register. The reset drops any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Operand, carry, slice index and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      idx_reg   <= '0;
    end else begin
      a_reg     <= a_next;
      b_reg     <= b_next;
      sum_reg   <= sum_next;
      carry_reg <= carry_next;
      cout_reg  <= cout_next;
      ovf_reg   <= ovf_next;
      idx_reg   <= idx_next;
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder.
// Instance u_w32 (WIDTH=32, CHUNK=8) runs a table of vectors and several
// hand-written multi-cycle sequences. Its results go through a scoreboard.
// Instances u_w3c1 and u_w3c3 run every 3-bit operand combination against an
// arithmetic model.
module tb_seq_chunk_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        start = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, cout, ovf;
  logic [31:0] sum;

  seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) u_w32 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  // 3-bit instances with shared inputs
  logic       sstart = 1'b0, ssub = 1'b0, scin = 1'b0;
  logic [2:0] sa = '0, sb = '0;
  logic       busy1, done1, cout1, ovf1, busy3, done3, cout3, ovf3;
  logic [2:0] sum1, sum3;

  seq_chunk_adder #(.WIDTH(3), .CHUNK(1)) u_w3c1 (
    .clk(clk), .rst_n(rst_n), .start(sstart), .sub(ssub), .a(sa), .b(sb), .cin(scin),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  seq_chunk_adder #(.WIDTH(3), .CHUNK(3)) u_w3c3 (
    .clk(clk), .rst_n(rst_n), .start(sstart), .sub(ssub), .a(sa), .b(sb), .cin(scin),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3), .ovf(ovf3)
  );

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ov;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ov;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Arithmetic reference model. The flags come from integer ranges, not from carry bits.
  function automatic void model(input int w, input longint ua, input longint ub,
                                input bit ci, input bit su,
                                output longint s, output bit co, output bit ov);
    longint md, sa_i, sb_i, r;
    md   = longint'(1) << w;
    sa_i = (ua >= md / 2) ? ua - md : ua;
    sb_i = (ub >= md / 2) ? ub - md : ub;
    if (!su) begin
      r  = ua + ub + longint'(ci);
      co = (r >= md);
      s  = r % md;
      r  = sa_i + sb_i + longint'(ci);
    end else begin
      co = (ua >= ub + longint'(ci));
      s  = (ua - ub - longint'(ci) + md) % md;
      r  = sa_i - sb_i - longint'(ci);
    end
    ov = (r < -(md / 2)) || (r >= md / 2);
  endfunction

  // Scoreboard check of u_w32: every done pops one expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_done: got sum=%0h with no expected result queued", sum);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if ({sum, cout, ovf} !== {e.s, e.co, e.ov}) begin
          bad++;
          $display("FAIL sb_result: got sum=%0h cout=%0b ovf=%0b expected sum=%0h cout=%0b ovf=%0b",
                   sum, cout, ovf, e.s, e.co, e.ov);
        end
      end
    end
  end

  task automatic wait_done(input int maxe, output int n);
    n = 0;
    for (int e = 1; e <= maxe; e++) begin
      @(posedge clk); #1;
      if (done) begin
        n = e;
        return;
      end
    end
  endtask

  // Run one u_w32 operation. Check latency, busy length, the one-cycle done pulse and that the result holds.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tci, input logic tsu,
                        input logic [31:0] es, input logic eco, input logic eov, input string nm);
    exp_t e;
    int lat, nbusy;
    logic busy_at_done;
    e.s = es; e.co = eco; e.ov = eov;
    sbq.push_back(e);
    @(negedge clk);
    a = ta; b = tb_v; cin = tci; sub = tsu; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~ta; b = ~tb_v;
    lat = 0; nbusy = 0; busy_at_done = 1'b1;
    for (int e2 = 1; e2 <= 20; e2++) begin
      if (e2 > 1) begin
        @(posedge clk); #1;
      end
      if (done) begin
        lat = e2;
        busy_at_done = busy;
        break;
      end
      if (busy) nbusy++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'd5);
    chk({nm, "_busy_cycles"}, 64'(nbusy), 64'd4);
    chk({nm, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
    @(posedge clk); #1;
    chk({nm, "_done_one_cycle"}, 64'(done), 64'd0);
    chk({nm, "_sum_hold"}, 64'(sum), 64'(es));
  endtask

  // Run one operation on both 3-bit instances and compare latency, busy and result for each.
  task automatic small_op(input logic [2:0] ua, input logic [2:0] ub, input logic ci, input logic su);
    longint es;
    bit eco, eov;
    int lat1, lat3;
    logic [5:0] r1, r3, ex;
    model(3, longint'(ua), longint'(ub), ci, su, es, eco, eov);
    ex = {1'b0, es[2:0], eco, eov};
    @(negedge clk);
    sa = ua; sb = ub; scin = ci; ssub = su; sstart = 1'b1;
    @(posedge clk); #1;
    sstart = 1'b0;
    lat1 = 0; lat3 = 0; r1 = '0; r3 = '0;
    for (int e = 1; e <= 8; e++) begin
      if (e > 1) begin
        @(posedge clk); #1;
      end
      if (done1 && lat1 == 0) begin
        lat1 = e; r1 = {busy1, sum1, cout1, ovf1};
      end
      if (done3 && lat3 == 0) begin
        lat3 = e; r3 = {busy3, sum3, cout3, ovf3};
      end
      if (lat1 != 0 && lat3 != 0) break;
    end
    chk($sformatf("w3c1 a=%0d b=%0d cin=%0b sub=%0b {lat,busy,sum,cout,ovf}", ua, ub, ci, su),
        {32'(lat1), 26'd0, r1}, {32'd4, 26'd0, ex});
    chk($sformatf("w3c3 a=%0d b=%0d cin=%0b sub=%0b {lat,busy,sum,cout,ovf}", ua, ub, ci, su),
        {32'(lat3), 26'd0, r3}, {32'd2, 26'd0, ex});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt0;
    longint ms;
    bit mco, mov;
    logic [31:0] ra, rb;
    logic rci, rsu;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h8000_0001, 1'b0, 1'b1};
    vecs[4] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[6] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0};
    vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

    // Values while reset is held
    #2;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_sum", 64'(sum), 64'd0);
    chk("reset_flags", 64'({cout, ovf}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Table of vectors
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].s, vecs[i].co, vecs[i].ov,
             $sformatf("vec%0d", i));
    end

    // Random operations checked against the model
    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom; rci = 1'($urandom_range(0, 1)); rsu = 1'($urandom_range(0, 1));
      model(32, longint'(ra), longint'(rb), rci, rsu, ms, mco, mov);
      run_op(ra, rb, rci, rsu, ms[31:0], mco, mov, $sformatf("rnd%0d", i));
    end

    // A start pulse during RUN, with other operands, must be ignored
    cnt0 = done_cnt;
    begin
      exp_t e;
      e.s = 32'h8000_0001; e.co = 1'b0; e.ov = 1'b1;
      sbq.push_back(e);
    end
    @(negedge clk);
    a = 32'h7FFF_FFFF; b = 32'h1; cin = 1'b1; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 32'h1; b = 32'h1; cin = 1'b0; sub = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(10, n);
    chk("ignore_start_latency", 64'(n), 64'd2);
    repeat (6) @(posedge clk);
    #1;
    chk("ignore_start_done_count", 64'(done_cnt - cnt0), 64'd1);
    chk("ignore_start_queue_empty", 64'(sbq.size()), 64'd0);

    // Back-to-back: start held high through the DONE cycle
    begin
      exp_t e;
      e.s = 32'd30; e.co = 1'b0; e.ov = 1'b0;
      sbq.push_back(e);
      e.s = 32'd7;
      sbq.push_back(e);
    end
    @(negedge clk);
    a = 32'd10; b = 32'd20; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 32'd3; b = 32'd4;
    wait_done(10, n);
    chk("b2b_first_latency", 64'(n), 64'd4);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_accept_busy", 64'(busy), 64'd1);
    chk("b2b_sum_held", 64'(sum), 64'd30);
    wait_done(10, n);
    chk("b2b_edges_between_dones", 64'(n + 1), 64'd5);
    @(posedge clk); #1;

    // Asynchronous reset while RUN is at slice 2
    run_op(32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "pre_reset");
    cnt0 = done_cnt;
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrun_busy_before_reset", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_busy", 64'(busy), 64'd0);
    chk("midrun_reset_done", 64'(done), 64'd0);
    chk("midrun_reset_sum", 64'(sum), 64'd0);
    chk("midrun_reset_flags", 64'({cout, ovf}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("midrun_no_done_after_release", 64'(done_cnt - cnt0), 64'd0);
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, "post_reset");

    // Every 3-bit combination on both instances
    for (int su = 0; su < 2; su++)
      for (int ci = 0; ci < 2; ci++)
        for (int ia = 0; ia < 8; ia++)
          for (int ib = 0; ib < 8; ib++)
            small_op(3'(ia), 3'(ib), 1'(ci), 1'(su));

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Multi-cycle, parametrised add/subtract unit for wide RSA operands in the EX-stage ALU.
- Processes one CHUNK-bit slice per cycle, LSB slice first, with a registered inter-slice carry.
- Lets the datapath reach large WIDTH without a long combinational carry chain.
- Uses a start/busy/done handshake and produces signed-overflow and carry flags alongside the result.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits added per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK (localparam), WIDTH/CHUNK, number of RUN cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled on rising clk edge when in IDLE or DONE.
- sub  in  1  0: a+b+cin; 1: a-b-cin (cin acts as borrow-in).
- a  in  WIDTH  operand A, sampled with start.
- b  in  WIDTH  operand B, sampled with start.
- cin  in  1  carry-in (add) / borrow-in (sub), sampled with start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when result valid.
- sum  out  WIDTH  result; held stable from done until next accepted start.
- cout  out  1  raw carry out of MSB; for sub, borrow-out = ~cout.
- ovf  out  1  two's-complement signed overflow of the operation.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, internal operand/carry registers=0. Applies immediately, including mid-RUN; the in-flight operation is discarded and no done is produced.
- States: IDLE, RUN, DONE.
- Transitions:
  - IDLE -> RUN on start=1.
  - RUN -> RUN while slice index < NCHUNK-1.
  - RUN -> DONE after processing slice NCHUNK-1.
  - DONE -> RUN if start=1, else DONE -> IDLE.
- Start acceptance (edge k): latch A=a, B=(sub ? ~b : b), carry=(sub ? ~cin : cin), slice index=0. sum, cout and ovf keep their previous values until overwritten.
- RUN slice i (edges k+1 .. k+NCHUNK):
  - {c, s} = A[i*CHUNK +: CHUNK] + B[i*CHUNK +: CHUNK] + carry.
  - Write sum[i*CHUNK +: CHUNK] = s; carry <= c.
  - On the last slice: cout = c; ovf = carry into MSB XOR c.
- Timing: after edge k+NCHUNK, state=DONE, done=1 for exactly one cycle, busy=0.
  - Latency: start edge to done visible = NCHUNK+1 edges.
  - Throughput: one operation per NCHUNK+1 cycles with back-to-back start.
- Intermediate sum bits are visible during RUN; only the value at done is architecturally valid.
- start during RUN: ignored; no queuing, no effect on the in-flight operation.
- start=1 in the DONE cycle: done still pulses; the new operation is accepted at that edge.
- Operands a, b, cin, sub may change freely after the accepting edge.
- NCHUNK=1: RUN lasts one cycle; behaviour is otherwise identical.
- Results are modulo 2^WIDTH; there is no saturation.

Test Plan:
- WIDTH=32/CHUNK=8, a=0xFFFFFFFF, b=0x1, cin=0, sub=0 -> sum=0x00000000, cout=1, ovf=0; busy high 4 cycles; done on 5th edge after start.
- sub=1, a=5, b=7, cin=0 -> sum=0xFFFFFFFE, cout=0 (borrow), ovf=0. Then a=0x80000000, b=1, cin=0 -> sum=0x7FFFFFFF, cout=1, ovf=1.
- add a=0x7FFFFFFF, b=1, cin=1 -> sum=0x80000001, ovf=1, cout=0. start pulsed during RUN with different operands -> ignored, same result, single done.
- Back-to-back: start held high through the DONE cycle with a=3, b=4 -> first done pulses, second op yields sum=7 exactly 5 edges later; sum holds the first result until overwritten.
- rst_n low at RUN slice 2 -> immediately busy=0, done=0, sum=0, flags 0; no done after release; a following op 0x12345678 + 0x11111111 -> 0x23456789.
- Exhaustive WIDTH=3/CHUNK=1 and WIDTH=3/CHUNK=3, all a, b, cin, sub -> sum/cout/ovf match a software model; done latency = NCHUNK+1 every time.
